// File: rtl/st_align_buf_pkg.sv
// Shared store-path definitions: STsel codes and the AdES exception code.
`default_nettype none
package mips_defs;
  localparam logic [2:0] ST_B     = 3'b001;
  localparam logic [2:0] ST_H     = 3'b010;
  localparam logic [2:0] ST_W     = 3'b011;
  localparam logic [4:0] EXC_ADES = 5'd5;
endpackage
`default_nettype wire

// File: rtl/st_align_buf_if.sv
// Store-request, load-hazard and memory-drain signal bundle for st_align_buf.
`default_nettype none
interface st_align_buf_if #(parameter int AW = 32);
  logic          st_valid;
  logic [2:0]    STsel;
  logic [AW-1:0] Addr;
  logic [31:0]   Din;
  logic          st_ready;
  logic          st_exc;
  logic [4:0]    ExcCode;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic          empty;

  modport master (
    output st_valid, STsel, Addr, Din, ld_addr, mem_ack,
    input  st_ready, st_exc, ExcCode, ld_hit, mem_we, mem_addr, mem_be, mem_wdata, empty
  );

  modport slave (
    input  st_valid, STsel, Addr, Din, ld_addr, mem_ack,
    output st_ready, st_exc, ExcCode, ld_hit, mem_we, mem_addr, mem_be, mem_wdata, empty
  );
endinterface
`default_nettype wire

// File: rtl/st_align_buf_lane_gen.sv
// st_lane_gen: combinational byte-enable / lane-replicated data / alignment check.
`default_nettype none
module st_lane_gen
  import mips_defs::*;
(
  input  logic [1:0]  i_a,
  input  logic [2:0]  i_stsel,
  input  logic [31:0] i_din,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic        o_code_ok
);
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = 32'h0;
    o_misaligned = 1'b0;
    o_code_ok    = 1'b0;
    case (i_stsel)
      ST_B: begin
        o_code_ok = 1'b1;
        o_be      = 4'b0001 << i_a;
        o_wdata   = {4{i_din[7:0]}};
      end
      ST_H: begin
        o_code_ok    = 1'b1;
        o_misaligned = i_a[0];
        o_be         = i_a[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_din[15:0]}};
      end
      ST_W: begin
        o_code_ok    = 1'b1;
        o_misaligned = |i_a;
        o_be         = 4'b1111;
        o_wdata      = i_din;
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/st_align_buf.sv
// st_align_buf: store alignment check, lane generation and in-order store FIFO
// draining to data memory, with same-word load hazard detection.
`default_nettype none
module st_align_buf
  import mips_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic clk,
  input  logic reset,
  st_align_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] C_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] C_PONE = PW'(1);

  logic [PW:0]   r_count;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic          r_exc;

  logic [AW-3:0] r_waddr [DEPTH];
  logic [3:0]    r_be    [DEPTH];
  logic [31:0]   r_data  [DEPTH];

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_mis;
  logic        w_code_ok;
  logic        w_ready;
  logic        w_we;
  logic        w_push;
  logic        w_pop;
  logic        w_hit;
  logic        w_unused;

  st_lane_gen u_lane (
    .i_a          (bus.Addr[1:0]),
    .i_stsel      (bus.STsel),
    .i_din        (bus.Din),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_mis),
    .o_code_ok    (w_code_ok)
  );

  assign w_ready  = (r_count != C_FULL);
  assign w_we     = (r_count != '0);
  assign w_push   = bus.st_valid & w_ready & w_code_ok & ~w_mis;
  assign w_pop    = bus.mem_ack & w_we;
  assign w_unused = ^bus.ld_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_exc   <= 1'b0;
    end else begin
      // Misalignment traps whether or not the FIFO has room.
      r_exc <= bus.st_valid & w_code_ok & w_mis;
      if (w_push) r_wr <= r_wr + C_PONE;
      if (w_pop)  r_rd <= r_rd + C_PONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_waddr[r_wr] <= bus.Addr[AW-1:2];
      r_be[r_wr]    <= w_be;
      r_data[r_wr]  <= w_wdata;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - r_rd} < r_count) && (r_waddr[i] == bus.ld_addr[AW-1:2]))
        w_hit = 1'b1;
    end
  end

  assign bus.st_ready  = w_ready;
  assign bus.st_exc    = r_exc;
  assign bus.ExcCode   = r_exc ? EXC_ADES : 5'd0;
  assign bus.ld_hit    = w_hit;
  assign bus.mem_we    = w_we;
  assign bus.mem_addr  = w_we ? {r_waddr[r_rd], 2'b00} : '0;
  assign bus.mem_be    = w_we ? r_be[r_rd] : 4'b0000;
  assign bus.mem_wdata = w_we ? r_data[r_rd] : 32'h0;
  assign bus.empty     = ~w_we;
endmodule
`default_nettype wire

// File: doc/st_align_buf.md
Name: st_align_buf

Overview:
- Store-side counterpart of the load extender: takes committed store requests (sb/sh/sw), checks alignment, and generates the 4-bit byte enable and lane-replicated write data.
- Queues accepted stores in a small FIFO and drains them to the data-memory/bridge port with a valid/ack handshake.
- Flags same-word hazards for concurrent loads so the pipeline can stall.
- Sits between the M stage and DM/bridge.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AW, 32, address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- st_valid  in  1  store request this cycle
- STsel  in  3  001 sb, 010 sh, 011 sw; other codes are ignored (no-op)
- Addr  in  AW  byte address
- Din  in  32  register data (right-justified)
- st_ready  out  1  FIFO can accept
- st_exc  out  1  one-cycle pulse, misaligned store (AdES)
- ExcCode  out  5  5 when st_exc, else 0
- ld_addr  in  AW  address of load in M
- ld_hit  out  1  pending store to same word as ld_addr
- mem_we  out  1  head entry valid toward memory
- mem_addr  out  AW  {Addr[AW-1:2],2'b00} of head
- mem_be  out  4  byte enables of head
- mem_wdata  out  32  lane-aligned data of head
- mem_ack  in  1  memory accepted head this cycle
- empty  out  1  no pending stores (used for eret/syscall drain)

Behaviour:
- Reset (async, active-high): count, rd/wr pointers and st_exc are cleared. Outputs go to st_ready=1, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, empty=1, ld_hit=0, ExcCode=0. Entries in flight are discarded, and mem_we drops immediately, without waiting for a clock edge.
- Accept: on a rising edge, accept when st_valid && st_ready && STsel is a valid code && aligned.
- st_ready = (count != DEPTH). It is combinational from registered state only.
- Alignment:
  - sb is always aligned.
  - sh is misaligned if Addr[0]=1.
  - sw is misaligned if Addr[1:0]!=0.
- Misaligned store with st_valid: nothing is enqueued; st_exc=1 and ExcCode=5 for exactly the following cycle (registered). This applies regardless of st_ready.
- Byte-enable and data generation (a = Addr[1:0]):
  - sb: be = 4'b0001 << a; wdata = {4{Din[7:0]}}.
  - sh: be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{Din[15:0]}}.
  - sw: be = 4'b1111; wdata = Din.
- Entry contents: word address, be, wdata. Latency is 1 cycle: a store accepted at edge N is visible on mem_* after edge N if the FIFO was empty.
- Drain:
  - mem_we = (count != 0).
  - mem_addr, mem_be and mem_wdata are driven from the head entry and held stable until the cycle in which mem_ack=1.
  - On mem_ack && mem_we, the head retires at the edge.
  - mem_ack while mem_we=0 is ignored.
- Simultaneous accept and retire:
  - count is unchanged and both pointers advance.
  - When full, st_ready=0, so an accept cannot coincide with full even if ack arrives. No bypass.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- ld_hit (combinational): 1 if any valid entry has word address == ld_addr[AW-1:2]. An entry retiring this cycle still counts as valid.
- empty = (count == 0).
- Ordering: strictly FIFO. No merging of stores to the same word.

Decomposition:
- Shared package (mips_defs) holds:
  - STsel codes ST_B=3'b001, ST_H=3'b010, ST_W=3'b011, matching the existing LDsel encoding style.
  - EXC_ADES=5'd5.
- One natural sub-module, st_lane_gen: purely combinational Addr[1:0]/STsel/Din → be, wdata, misaligned.
- The FIFO storage and pointer logic stay in st_align_buf.

Test Plan:
- Byte lanes: with mem_ack=0, send sb at Addr=0x00000013, Din=0x000000AB. Required next cycle: mem_we=1, mem_addr=0x10, mem_be=4'b1000, mem_wdata=0xABABABAB.
- Halfword and word: sh at Addr 0x22, Din=0x1234BEEF gives be=1100 and wdata=0xBEEFBEEF. sw at Addr 0x40, Din=0xDEADBEEF gives be=1111 and wdata=0xDEADBEEF.
- Misaligned: sw at Addr 0x41 or sh at 0x23 produces st_exc=1 and ExcCode=5 for one cycle; count is unchanged and mem_we stays 0.
- Full and back-pressure:
  - Hold mem_ack=0 and issue 5 sw stores to 0x0, 0x4, 0x8, 0xC, 0x10.
  - After 4 stores, st_ready=0 and the 5th is not accepted.
  - Then pulse mem_ack: stores drain in order 0x0, 0x4, 0x8, 0xC.
  - The 5th store is accepted once st_ready=1.
  - Also cover enqueue and ack in the same cycle at count=2: count stays 2.
- Hazard: with a pending sb at 0x106, ld_addr=0x104 gives ld_hit=1, and ld_addr=0x108 gives ld_hit=0. After the ack retires the entry, ld_hit=0 for 0x104.
- Reset mid-drain: with 3 pending entries and mem_we=1, assert reset between edges. mem_we=0 and empty=1 immediately. After release, the FIFO is empty and a new sb is accepted normally.
